// File: rtl/hdmi_init_seq.sv
// HDMI transmitter configuration sequencer: walks a register/data table and issues
// each pair as an I2C write, retrying NACKed writes after a backoff and replaying on hot-plug.
module hdmi_init_seq #(
    parameter int         NUM_REGS    = 16,
    parameter int         IDX_W       = 8,
    parameter logic [7:0] DEV_ADDR    = 8'h72,
    parameter int         MAX_RETRIES = 3,
    parameter int         BACKOFF_CYC = 50000
) (
    input  logic             clk_ref,
    input  logic             reset_n,
    input  logic             hpd,
    input  logic             go,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [7:0]       tbl_reg,
    input  logic [7:0]       tbl_data,
    output logic             i2c_start,
    output logic [7:0]       i2c_dev_addr,
    output logic [7:0]       i2c_reg_addr,
    output logic [7:0]       i2c_data,
    input  logic             i2c_ready,
    input  logic             i2c_ack_err,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx,
    output logic [3:0]       state_out
);

    // state     | meaning
    // S_IDLE    | waiting for go or hot-plug edge
    // S_FETCH   | one cycle for the ROM, then latch reg/data
    // S_ISSUE   | pulse i2c_start once the controller is ready
    // S_WAIT_BUSY | wait for the controller to accept (ready low)
    // S_WAIT_DONE | wait for ready high, evaluate ack_err
    // S_BACKOFF | delay before re-issuing a NACKed entry
    localparam logic [3:0] S_IDLE      = 4'b0001;
    localparam logic [3:0] S_FETCH     = 4'b0010;
    localparam logic [3:0] S_ISSUE     = 4'b0100;
    localparam logic [3:0] S_WAIT_BUSY = 4'b0101;
    localparam logic [3:0] S_WAIT_DONE = 4'b1000;
    localparam logic [3:0] S_BACKOFF   = 4'b1001;

    localparam int               BO_W     = $clog2(BACKOFF_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]       MAX_RTY  = 4'(MAX_RETRIES);
    localparam logic [BO_W-1:0]  BO_LOAD  = BO_W'(BACKOFF_CYC);

    logic [3:0]      state;
    logic [3:0]      retry_cnt;
    logic [BO_W-1:0] bo_cnt;
    logic            fetch_wait;
    logic            restart_pend;
    logic            restart_now;
    logic            rst_meta, rst_sync_n;
    logic            hpd_s1, hpd_s2, hpd_d;
    logic            hpd_rise;

    assign i2c_dev_addr = DEV_ADDR;

    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Synchroniser flops clear on reset so an hpd already high at release yields one edge.
    always_ff @(posedge clk_ref or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            hpd_s1 <= 1'b0;
            hpd_s2 <= 1'b0;
            hpd_d  <= 1'b0;
        end else begin
            hpd_s1 <= hpd;
            hpd_s2 <= hpd_s1;
            hpd_d  <= hpd_s2;
        end
    end

    assign hpd_rise = hpd_s2 & ~hpd_d;

    // A hot-plug restart never cuts an in-flight transfer; it waits for ready to return.
    always_comb begin
        restart_now = 1'b0;
        case (state)
            S_FETCH, S_ISSUE, S_BACKOFF: restart_now = hpd_rise | restart_pend;
            S_WAIT_DONE:                 restart_now = i2c_ready & (hpd_rise | restart_pend);
            default:                     restart_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= S_IDLE;
            tbl_idx      <= '0;
            i2c_start    <= 1'b0;
            i2c_reg_addr <= 8'h00;
            i2c_data     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_idx      <= '0;
            retry_cnt    <= 4'd0;
            bo_cnt       <= '0;
            fetch_wait   <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            i2c_start <= 1'b0;
            if (hpd_rise && state != S_IDLE)
                restart_pend <= 1'b1;
            if (restart_now) begin
                state        <= S_FETCH;
                tbl_idx      <= '0;
                retry_cnt    <= 4'd0;
                fetch_wait   <= 1'b1;
                restart_pend <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go || hpd_rise) begin
                            state        <= S_FETCH;
                            tbl_idx      <= '0;
                            retry_cnt    <= 4'd0;
                            fetch_wait   <= 1'b1;
                            done         <= 1'b0;
                            error        <= 1'b0;
                            busy         <= 1'b1;
                            restart_pend <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        if (fetch_wait) begin
                            fetch_wait <= 1'b0;
                        end else begin
                            i2c_reg_addr <= tbl_reg;
                            i2c_data     <= tbl_data;
                            state        <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (i2c_ready) begin
                            i2c_start <= 1'b1;
                            state     <= S_WAIT_BUSY;
                        end
                    end
                    S_WAIT_BUSY: begin
                        if (!i2c_ready)
                            state <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (i2c_ready) begin
                            if (!i2c_ack_err) begin
                                if (tbl_idx == LAST_IDX) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
                                end else begin
                                    tbl_idx    <= tbl_idx + 1'b1;
                                    retry_cnt  <= 4'd0;
                                    fetch_wait <= 1'b1;
                                    state      <= S_FETCH;
                                end
                            end else if (retry_cnt < MAX_RTY) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                bo_cnt    <= BO_LOAD;
                                state     <= S_BACKOFF;
                            end else begin
                                error   <= 1'b1;
                                err_idx <= tbl_idx;
                                busy    <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    S_BACKOFF: begin
                        if (bo_cnt <= BO_W'(1))
                            state <= S_ISSUE;
                        else
                            bo_cnt <= bo_cnt - 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        case (state)
            S_IDLE, S_FETCH, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_BACKOFF: state_out = state;
            default: state_out = 4'b1111;
        endcase
    end

endmodule

// File: tb/tb_hdmi_init_seq.sv
// Directed/randomized bench for hdmi_init_seq with a ROM model, an I2C controller
// responder driven by a per-entry NACK plan, and a table-walk reference model.
module tb_hdmi_init_seq;

    localparam int NREG  = 4;
    localparam int MAXR  = 3;
    localparam int BOCYC = 10;

    logic       clk_ref = 1'b0;
    logic       reset_n = 1'b0;
    logic       hpd = 1'b0;
    logic       go = 1'b0;
    logic [7:0] tbl_idx;
    logic [7:0] tbl_reg = 8'h00;
    logic [7:0] tbl_data = 8'h00;
    logic       i2c_start;
    logic [7:0] i2c_dev_addr, i2c_reg_addr, i2c_data;
    logic       i2c_ready = 1'b1;
    logic       i2c_ack_err = 1'b0;
    logic       busy, done, error;
    logic [7:0] err_idx;
    logic [3:0] state_out;

    hdmi_init_seq #(
        .NUM_REGS(NREG), .IDX_W(8), .DEV_ADDR(8'h72),
        .MAX_RETRIES(MAXR), .BACKOFF_CYC(BOCYC)
    ) dut (
        .clk_ref(clk_ref), .reset_n(reset_n), .hpd(hpd), .go(go),
        .tbl_idx(tbl_idx), .tbl_reg(tbl_reg), .tbl_data(tbl_data),
        .i2c_start(i2c_start), .i2c_dev_addr(i2c_dev_addr),
        .i2c_reg_addr(i2c_reg_addr), .i2c_data(i2c_data),
        .i2c_ready(i2c_ready), .i2c_ack_err(i2c_ack_err),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .state_out(state_out)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        int         run;
        int         ent;
        logic [7:0] dev;
        logic [7:0] rg;
        logic [7:0] dt;
        int         cyc;
    } xact_t;

    logic [7:0] rom_reg  [NREG];
    logic [7:0] rom_data [NREG];
    int         plan     [NREG];
    int         run_id = 0;
    bit         long_mode = 1'b0;

    xact_t log_q[$];
    int    cyc = 0;
    int    consec = 0;
    logic  start_q = 1'b0;
    int    xfer_left = 0;
    logic  nack_next = 1'b0;

    int total = 0;
    int bad = 0;

    always @(posedge clk_ref) begin
        tbl_reg  <= rom_reg[tbl_idx[1:0]];
        tbl_data <= rom_data[tbl_idx[1:0]];
    end

    // I2C controller responder: NACKs the first plan[e] attempts on entry e of the current run.
    always @(posedge clk_ref) begin
        int    e;
        int    k;
        xact_t x;
        cyc <= cyc + 1;
        if (i2c_start && start_q) consec <= consec + 1;
        start_q <= i2c_start;
        if (i2c_ready && i2c_start) begin
            e = -1;
            for (int i = 0; i < NREG; i++)
                if (rom_reg[i] == i2c_reg_addr) e = i;
            k = 0;
            foreach (log_q[j])
                if (log_q[j].run == run_id && log_q[j].ent == e) k++;
            x.run = run_id; x.ent = e; x.dev = i2c_dev_addr;
            x.rg = i2c_reg_addr; x.dt = i2c_data; x.cyc = cyc;
            log_q.push_back(x);
            nack_next <= (e >= 0) && (k < plan[e >= 0 ? e : 0]);
            i2c_ready <= 1'b0;
            xfer_left <= long_mode ? 20 : int'($urandom_range(2, 6));
        end else if (!i2c_ready) begin
            if (xfer_left <= 1) begin
                i2c_ready   <= 1'b1;
                i2c_ack_err <= nack_next;
            end else begin
                xfer_left <= xfer_left - 1;
            end
        end
    end

    int exp_q[$];
    bit exp_done, exp_err;
    int exp_eidx;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic new_table();
        for (int i = 0; i < NREG; i++) begin
            rom_reg[i]  = 8'(i * 64) | 8'($urandom_range(0, 63));
            rom_data[i] = 8'($urandom_range(0, 255));
            plan[i]     = 0;
        end
    endtask

    // Reference: each entry takes min(nacks, MAXR)+1 attempts; exceeding MAXR aborts the run.
    task automatic build_exp();
        int n;
        exp_q.delete();
        exp_done = 1'b1; exp_err = 1'b0; exp_eidx = 0;
        for (int e = 0; e < NREG; e++) begin
            n = (plan[e] > MAXR) ? MAXR + 1 : plan[e] + 1;
            repeat (n) exp_q.push_back(e);
            if (plan[e] > MAXR) begin
                exp_done = 1'b0; exp_err = 1'b1; exp_eidx = e;
                break;
            end
        end
    endtask

    task automatic pulse_go();
        @(negedge clk_ref); go = 1'b1;
        @(posedge clk_ref); #1; go = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(posedge clk_ref); #1; n++;
        end
        chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_run(string name);
        xact_t act[$];
        foreach (log_q[j]) if (log_q[j].run == run_id) act.push_back(log_q[j]);
        chk({name, "_count"}, act.size(), exp_q.size());
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_ent%0d", name, i), act[i].ent, exp_q[i]);
            chk($sformatf("%s_reg%0d", name, i), {24'd0, act[i].rg}, {24'd0, rom_reg[exp_q[i]]});
            chk($sformatf("%s_dat%0d", name, i), {24'd0, act[i].dt}, {24'd0, rom_data[exp_q[i]]});
            chk($sformatf("%s_dev%0d", name, i), {24'd0, act[i].dev}, 32'h72);
            if (i > 0 && exp_q[i] == exp_q[i-1])
                chk($sformatf("%s_backoff%0d", name, i),
                    {31'd0, (act[i].cyc - act[i-1].cyc) >= BOCYC}, 32'd1);
        end
        chk({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
        if (exp_err) chk({name, "_err_idx"}, {24'd0, err_idx}, exp_eidx);
        chk({name, "_tbl_idx"}, {24'd0, tbl_idx}, exp_q[exp_q.size()-1]);
        chk({name, "_state"}, {28'd0, state_out}, 32'h1);
    endtask

    task automatic chk_reset_vals(string name);
        chk({name, "_start"}, {31'd0, i2c_start}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
        chk({name, "_error"}, {31'd0, error}, 32'd0);
        chk({name, "_state"}, {28'd0, state_out}, 32'h1);
        chk({name, "_idx"}, {24'd0, tbl_idx}, 32'd0);
        chk({name, "_err_idx"}, {24'd0, err_idx}, 32'd0);
        chk({name, "_reg"}, {24'd0, i2c_reg_addr}, 32'd0);
        chk({name, "_data"}, {24'd0, i2c_data}, 32'd0);
        chk({name, "_dev"}, {24'd0, i2c_dev_addr}, 32'h72);
    endtask

    initial begin
        int n;
        new_table();
        repeat (3) @(posedge clk_ref);
        #1;
        chk_reset_vals("rst");
        @(negedge clk_ref); reset_n = 1'b1;
        repeat (5) @(posedge clk_ref);

        // Plain run with go latency check
        run_id++; build_exp();
        pulse_go();
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(posedge clk_ref); #1; chk("lat_c1", {31'd0, i2c_start}, 32'd0);
        @(posedge clk_ref); #1; chk("lat_c2", {31'd0, i2c_start}, 32'd0);
        @(posedge clk_ref); #1; chk("lat_c3", {31'd0, i2c_start}, 32'd1);
        wait_idle("ack"); check_run("ack");

        // Entry 2 NACKs once
        new_table(); plan[2] = 1; run_id++; build_exp();
        pulse_go(); wait_idle("nack1"); check_run("nack1");

        // Entry 1 always NACKs
        new_table(); plan[1] = 99; run_id++; build_exp();
        pulse_go(); wait_idle("nackall"); check_run("nackall");

        // Randomized NACK plans
        for (int r = 0; r < 4; r++) begin
            new_table();
            for (int e = 0; e < NREG; e++) plan[e] = int'($urandom_range(0, 4));
            run_id++; build_exp();
            pulse_go(); wait_idle($sformatf("rnd%0d", r)); check_run($sformatf("rnd%0d", r));
        end

        // hpd rises while entry 2 is in flight: replay from entry 0
        new_table(); long_mode = 1'b1; run_id++;
        pulse_go();
        n = 0;
        while (n < 500 && !(log_q.size() > 0 && log_q[log_q.size()-1].run == run_id
                            && log_q[log_q.size()-1].ent == 2)) begin
            @(posedge clk_ref); #1; n++;
        end
        chk("hpd_reach2", {31'd0, n < 500}, 32'd1);
        hpd = 1'b1;
        wait_idle("hpd_restart");
        long_mode = 1'b0;
        exp_q = '{0, 1, 2, 0, 1, 2, 3}; exp_done = 1'b1; exp_err = 1'b0;
        check_run("hpd_restart");
        n = log_q.size();
        @(negedge clk_ref); hpd = 1'b0;
        repeat (10) @(posedge clk_ref);
        #1;
        chk("hpd_fall_busy", {31'd0, busy}, 32'd0);
        chk("hpd_fall_nostart", log_q.size(), n);

        // Reset during WAIT_BUSY
        new_table(); run_id++;
        pulse_go();
        n = 0;
        while (i2c_start !== 1'b1 && n < 50) begin
            @(posedge clk_ref); #1; n++;
        end
        chk("rstmid_seen_start", {31'd0, i2c_start}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rstmid");
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref); reset_n = 1'b1;
        n = 0;
        while (i2c_ready !== 1'b1 && n < 50) begin
            @(posedge clk_ref); #1; n++;
        end
        repeat (4) @(posedge clk_ref);
        run_id++; build_exp();
        pulse_go(); wait_idle("rstmid_run"); check_run("rstmid_run");

        // go while busy is ignored
        new_table(); run_id++; build_exp();
        pulse_go();
        repeat (8) @(posedge clk_ref);
        pulse_go();
        wait_idle("go_busy"); check_run("go_busy");

        // go coincident with an hpd edge gives one run
        new_table(); run_id++; build_exp();
        @(negedge clk_ref); hpd = 1'b1;
        @(negedge clk_ref);
        @(negedge clk_ref); go = 1'b1;
        @(posedge clk_ref); #1; go = 1'b0;
        wait_idle("go_hpd"); check_run("go_hpd");
        @(negedge clk_ref); hpd = 1'b0;
        repeat (6) @(posedge clk_ref);

        // hpd already high at reset release: exactly one run
        reset_n = 1'b0; hpd = 1'b1;
        new_table(); run_id++; build_exp();
        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref); reset_n = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(posedge clk_ref); #1; n++;
        end
        chk("hpd_at_rst_start", {31'd0, busy}, 32'd1);
        wait_idle("hpd_at_rst"); check_run("hpd_at_rst");
        repeat (10) @(posedge clk_ref);
        #1;
        chk("hpd_at_rst_single", {31'd0, busy}, 32'd0);
        hpd = 1'b0;

        chk("start_never_consecutive", consec, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_init_seq.md
# hdmi_init_seq

Parametrised HDMI transmitter configuration sequencer. It is the successor to the single-write init block. It walks a table of NUM_REGS register/data pairs and issues each one as an I2C write through the existing i2c_controller start/ready handshake. A write that NACKs is retried up to MAX_RETRIES times with a backoff delay, and the whole table is replayed on every hot-plug-detect rising edge. It sits between the top-level board wrapper and i2c_controller, and drives status LEDs.

## Interface
Parameters:
- NUM_REGS, 16: number of table entries (1..256).
- IDX_W, 8: table index width; must satisfy 2^IDX_W >= NUM_REGS.
- DEV_ADDR, 8'h72: 8-bit I2C write address placed on i2c_dev_addr.
- MAX_RETRIES, 3: extra attempts per entry after the first NACK (0..15).
- BACKOFF_CYC, 50000: clk_ref cycles to wait before a retry (>= 1).

Ports:
- clk_ref, in, 1: system clock, 50 MHz.
- reset_n, in, 1: asynchronous, active-low reset.
- hpd, in, 1: hot-plug detect, asynchronous; synchronised internally with 2 flops.
- go, in, 1: single-cycle request to run the table from entry 0.
- tbl_idx, out, IDX_W: current table index to the external ROM.
- tbl_reg, in, 8: register address at tbl_idx, valid 1 cycle after tbl_idx changes.
- tbl_data, in, 8: data at tbl_idx, same timing as tbl_reg.
- i2c_start, out, 1: write request pulse to i2c_controller.
- i2c_dev_addr, out, 8: constant DEV_ADDR.
- i2c_reg_addr, out, 8: registered tbl_reg.
- i2c_data, out, 8: registered tbl_data.
- i2c_ready, in, 1: controller idle; falls while a transfer is in progress.
- i2c_ack_err, in, 1: NACK flag, sampled on the cycle i2c_ready rises.
- busy, out, 1: sequence in progress.
- done, out, 1: last run completed without error; sticky until the next run starts.
- error, out, 1: an entry exhausted its retries; sticky until the next run starts.
- err_idx, out, IDX_W: index of the failing entry, valid while error = 1.
- state_out, out, 4: one-hot-style state code for LEDs.

## Operation
State machine (state_out code in brackets):
- IDLE [0001]: busy = 0. A go pulse or a synchronised hpd rising edge → FETCH, with tbl_idx = 0, retry count = 0, done = 0, error = 0.
- FETCH [0010]: wait 1 cycle for the ROM, then latch tbl_reg and tbl_data into i2c_reg_addr and i2c_data → ISSUE.
- ISSUE [0100]: when i2c_ready = 1, assert i2c_start for exactly 1 cycle → WAIT_BUSY. While i2c_ready = 0, hold in ISSUE.
- WAIT_BUSY [0101]: wait for i2c_ready = 0 → WAIT_DONE.
- WAIT_DONE [1000]: on the cycle i2c_ready = 1, sample i2c_ack_err.
  - ack_err = 0, not the last entry: tbl_idx + 1, retry count = 0 → FETCH.
  - ack_err = 0, tbl_idx = NUM_REGS-1: done = 1 → IDLE.
  - ack_err = 1, retry count < MAX_RETRIES: retry count + 1 → BACKOFF.
  - ack_err = 1, retry count = MAX_RETRIES: error = 1, err_idx = tbl_idx → IDLE.
- BACKOFF [1001]: count BACKOFF_CYC cycles → ISSUE. i2c_reg_addr and i2c_data are held; the entry is not refetched.
- Unused state encodings → IDLE. state_out reads 1111 for one cycle on this recovery.

Priority and corner rules:
- An hpd rising edge while busy restarts the run: the current transfer completes, its result is discarded, and the sequencer goes to FETCH at index 0. This is required so a partially configured sink is never left behind.
- A go pulse while busy is ignored.
- go and an hpd edge in the same cycle count as one start.
- A falling edge on hpd does nothing.
- The retry counter is wide enough for MAX_RETRIES = 15 with no wrap.
- The backoff counter is sized as clog2(BACKOFF_CYC+1).

## Timing
- Reset (async assert, release synchronised to clk_ref) values:
  - state = IDLE, tbl_idx = 0, i2c_start = 0, i2c_reg_addr = 0, i2c_data = 0, i2c_dev_addr = DEV_ADDR.
  - busy = 0, done = 0, error = 0, err_idx = 0, state_out = 0001.
  - hpd synchroniser flops = 0, so hpd already high at release produces one edge and one run.
- Reset asserted mid-transfer drops i2c_start immediately. The sequencer does not wait for the controller.
- Latency from go to the first i2c_start, with i2c_ready high: 3 cycles (IDLE → FETCH → FETCH latch → ISSUE pulse).
- hpd edge latency: 2 synchroniser cycles plus 1 edge-detect cycle, then the same path as go.
- Per-entry overhead beyond the I2C transfer: 4 cycles.
- busy rises on the cycle after the start request. It falls on the same edge that sets done or error.
- i2c_start is never asserted on 2 consecutive cycles.

## Test plan
- NUM_REGS = 4, controller model always ACKs, go pulse → four i2c_start pulses with (reg, data) = table[0..3] in order; done = 1, error = 0, tbl_idx ends at 3.
- Entry 2 NACKs once, then ACKs, BACKOFF_CYC = 10 → entry 2 is issued twice, ≥ 10 cycles apart, with identical reg/data; done = 1.
- Entry 1 always NACKs, MAX_RETRIES = 3 → 4 attempts on entry 1; error = 1, err_idx = 1, done = 0, no attempt on entry 2.
- hpd rises while entry 2 is in WAIT_DONE → entry 2 completes, next i2c_start carries table[0], full replay, done = 1.
- reset_n pulsed low during WAIT_BUSY → all outputs at reset values within the same cycle; a following go runs cleanly from index 0.
- go held for 1 cycle while busy, and go together with an hpd edge → exactly one run each, with no duplicated i2c_start.
